nand_flash_responder: RTL

Synthesizable single-die NAND flash responder: the device end of the flash bus that the NFC controller drives.
- Decodes CLE/ALE/WEN/REN strobes and the IO byte bus, holds a page array plus a page register, and drives F_RB and the read data.
- Instantiated twice in the system bench (flash A and flash B) so controller copies run fully synchronous with no behavioural models.

---
 rtl/nand_flash_responder.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/nand_flash_responder.sv
// Single-die NAND flash device model: decodes CLE/ALE/WEN/REN strobes, holds page array + page register.
// Read data appears 1 clk after REN low is sampled; F_RB=0 while busy, and only FFh is accepted then.
module nand_flash_responder #(
  parameter int PAGE_BYTES = 512,
  parameter int NUM_PAGES  = 16,
  parameter int T_R        = 16,
  parameter int T_PROG     = 32,
  parameter int T_RST      = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] F_IO_IN,
  output logic [7:0] F_IO_OUT,
  output logic       F_IO_DRIVE,
  input  logic       F_CLE,
  input  logic       F_ALE,
  input  logic       F_REN,
  input  logic       F_WEN,
  output logic       F_RB
);

  localparam int CW = $clog2(PAGE_BYTES);
  localparam int PW = (NUM_PAGES > 1) ? $clog2(NUM_PAGES) : 1;

  typedef enum logic [3:0] {
    IDLE, ADDR, READ_LOAD, READ_WAIT, READ_OUT, PROG_IN, PROG_COPY, PROG_WAIT, RST_WAIT
  } state_t;

  state_t          r_state;
  logic            r_op_prog;
  logic            r_half;
  logic [CW-1:0]   r_col;
  logic [15:0]     r_row;
  logic [1:0]      r_acnt;
  logic [15:0]     r_cnt;
  logic [PAGE_BYTES-1:0] r_mask;
  logic            r_rb;
  logic [7:0]      r_dout;
  logic            r_drive;
  logic            r_wen_q;
  logic            r_ren_q;
  logic [7:0]      r_preg  [PAGE_BYTES];
  logic [7:0]      r_array [NUM_PAGES*PAGE_BYTES];

  logic            w_wen_rise, w_ren_fall, w_ren_rise;
  logic            w_cmd, w_addr, w_data, w_busy, w_abort;
  logic [PW-1:0]   w_page;
  logic [CW-1:0]   w_cnt_col;
  logic [PW+CW-1:0] w_arr_idx;
  logic            w_arr_we, w_preg_load, w_preg_wr;

  assign w_wen_rise = !r_wen_q && F_WEN;
  assign w_ren_fall = r_ren_q && !F_REN;
  assign w_ren_rise = !r_ren_q && F_REN;
  assign w_cmd      = w_wen_rise && F_CLE && !F_ALE;
  assign w_addr     = w_wen_rise && F_ALE && !F_CLE;
  assign w_data     = w_wen_rise && !F_CLE && !F_ALE;
  assign w_busy     = r_state inside {READ_LOAD, READ_WAIT, PROG_COPY, PROG_WAIT, RST_WAIT};
  assign w_abort    = w_cmd && (F_IO_IN == 8'hFF);

  assign w_page     = PW'(32'(r_row) % NUM_PAGES);
  assign w_cnt_col  = r_cnt[CW-1:0];
  assign w_arr_idx  = {w_page, w_cnt_col};

  // An FFh or rst on the same edge stops the copy before that byte moves.
  assign w_arr_we    = !rst && !w_abort && (r_state == PROG_COPY) && r_mask[w_cnt_col];
  assign w_preg_load = !rst && !w_abort && (r_state == READ_LOAD);
  assign w_preg_wr   = !rst && w_data && (r_state == PROG_IN);

  always_ff @(posedge clk) begin
    if (w_arr_we) r_array[w_arr_idx] <= r_preg[w_cnt_col];
  end

  always_ff @(posedge clk) begin
    if (w_preg_load)    r_preg[w_cnt_col] <= r_array[w_arr_idx];
    else if (w_preg_wr) r_preg[r_col]     <= F_IO_IN;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_op_prog <= 1'b0;
      r_half    <= 1'b0;
      r_col     <= '0;
      r_row     <= '0;
      r_acnt    <= '0;
      r_cnt     <= '0;
      r_mask    <= '0;
      r_rb      <= 1'b1;
      r_dout    <= 8'h00;
      r_drive   <= 1'b0;
      r_wen_q   <= 1'b1;
      r_ren_q   <= 1'b1;
    end else begin
      r_wen_q <= F_WEN;
      r_ren_q <= F_REN;
      if (w_ren_rise) r_drive <= 1'b0;
      if (w_busy) begin
        if (w_abort) begin
          r_state <= RST_WAIT;
          r_cnt   <= '0;
          r_rb    <= 1'b0;
        end else begin
          case (r_state)
            READ_LOAD: begin
              if (r_cnt == 16'(PAGE_BYTES - 1)) begin
                r_state <= READ_WAIT;
                r_cnt   <= '0;
              end else r_cnt <= r_cnt + 16'd1;
            end
            READ_WAIT: begin
              if (r_cnt == 16'(T_R - 1)) begin
                r_state <= READ_OUT;
                r_rb    <= 1'b1;
              end else r_cnt <= r_cnt + 16'd1;
            end
            PROG_COPY: begin
              if (r_cnt == 16'(PAGE_BYTES - 1)) begin
                r_state <= PROG_WAIT;
                r_cnt   <= '0;
              end else r_cnt <= r_cnt + 16'd1;
            end
            PROG_WAIT: begin
              if (r_cnt == 16'(T_PROG - 1)) begin
                r_state <= IDLE;
                r_rb    <= 1'b1;
              end else r_cnt <= r_cnt + 16'd1;
            end
            RST_WAIT: begin
              if (r_cnt == 16'(T_RST - 1)) begin
                r_state <= IDLE;
                r_rb    <= 1'b1;
                r_half  <= 1'b0;
              end else r_cnt <= r_cnt + 16'd1;
            end
            default: r_state <= IDLE;
          endcase
        end
      end else if (w_wen_rise) begin
        // A WEN latch always wins over a REN fall in the same cycle.
        if (w_cmd) begin
          r_drive <= 1'b0;
          case (F_IO_IN)
            8'h00: begin
              r_half <= 1'b0; r_op_prog <= 1'b0; r_state <= ADDR; r_acnt <= '0;
            end
            8'h01: begin
              r_half <= 1'b1; r_op_prog <= 1'b0; r_state <= ADDR; r_acnt <= '0;
            end
            8'h80: begin
              r_op_prog <= 1'b1; r_mask <= '0; r_state <= ADDR; r_acnt <= '0;
            end
            8'h10: begin
              if (r_state == PROG_IN) begin
                r_state <= PROG_COPY;
                r_cnt   <= '0;
                r_rb    <= 1'b0;
              end else r_state <= IDLE;
            end
            8'hFF: begin
              r_state <= RST_WAIT;
              r_cnt   <= '0;
              r_rb    <= 1'b0;
            end
            default: r_state <= IDLE;
          endcase
        end else if (w_addr && r_state == ADDR) begin
          case (r_acnt)
            2'd0:    begin r_col <= CW'({r_half, F_IO_IN}); r_acnt <= 2'd1; end
            2'd1:    begin r_row[7:0] <= F_IO_IN; r_acnt <= 2'd2; end
            default: begin
              r_row[15:8] <= F_IO_IN;
              r_acnt      <= '0;
              r_cnt       <= '0;
              r_state     <= r_op_prog ? PROG_IN : READ_LOAD;
              r_rb        <= r_op_prog;
            end
          endcase
        end else if (w_data && r_state == PROG_IN) begin
          r_mask[r_col] <= 1'b1;
          r_col         <= r_col + 1'b1;
        end
      end else if (w_ren_fall && r_state == READ_OUT) begin
        r_dout  <= r_preg[r_col];
        r_drive <= 1'b1;
        r_col   <= r_col + 1'b1;
      end
    end
  end

  assign F_IO_OUT   = r_dout;
  assign F_IO_DRIVE = r_drive;
  assign F_RB       = r_rb;

endmodule
